// File: rtl/osc_meas_sched_if.sv
`default_nettype none
// ============================================================================
// Interface : osc_meas_sched_if
// Purpose   : Wishbone classic slave bundle for the oscillator measurement
//             scheduler.
// Signals   : wbs_stb_i, wbs_cyc_i, wbs_we_i  - strobe / cycle / write enable
//             wbs_sel_i[3:0]                   - byte lane selects
//             wbs_adr_i[31:0]                  - byte address
//             wbs_dat_i[31:0]                  - write data
//             wbs_ack_o                        - transfer acknowledge
//             wbs_dat_o[31:0]                  - read data
// Modports  : master (bus side), slave (scheduler side)
// Revision  : 1.0 - initial release
// ============================================================================
interface osc_meas_sched_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/osc_meas_sched.sv
`default_nettype none
// ============================================================================
// Module   : osc_meas_sched
// Purpose  : Wishbone slave that time-shares one edge counter between two ring
//            oscillators. Each selected oscillator is enabled, allowed to
//            settle, then its synchronised rising edges are counted over a
//            programmable gate window and stored in a result register.
// Ports    : wb_clk_i        - system clock
//            wb_rst_ni       - asynchronous active-low reset
//            wbs             - Wishbone slave bundle (osc_meas_sched_if.slave)
//            osc_in_i[1:0]   - asynchronous oscillator outputs
//            osc_en_o[1:0]   - oscillator enables (one-hot or zero)
//            busy_o          - sweep in progress
//            irq_o           - sweep-done interrupt (level, mirrors DONE)
// Map      : 0x0 CTRL  [0] START  [1] CONT  [3:2] MASK  [4] DONE(W1C)  [5] ABORT
//            0x4 GATE  [23:0] gate window in clock cycles (0 acts as 1)
//            0x8 RES0 / 0xC RES1  [CNT_W-1:0] count, [31] VALID
// Revision : 1.0 - initial release
// ============================================================================
module osc_meas_sched #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
    parameter int          CNT_W      = 24,
    parameter int          SETTLE_CYC = 64
) (
    input  wire logic            wb_clk_i,
    input  wire logic            wb_rst_ni,
    osc_meas_sched_if.slave      wbs,
    input  wire logic [1:0]      osc_in_i,
    output logic      [1:0]      osc_en_o,
    output logic                 busy_o,
    output logic                 irq_o
);

    localparam logic [23:0]      c_SETTLE_LAST = 24'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_STORE   = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_ack;
    logic [31:0]      r_dat_o, w_rdata;
    logic             r_cont, r_done;
    logic [1:0]       r_mask, r_mask_act, w_mask_now;
    logic [23:0]      r_gate, r_gate_act, r_tmr;
    logic             r_ch, w_ch_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_res_cnt [2];
    logic [1:0]       r_res_vld;
    logic [1:0]       r_sync1, r_sync2, r_prev;
    logic             w_hit, w_acc, w_wr_ctrl, w_wr_gate, w_start, w_abort, w_edge;
    logic             w_sweep_start, w_valid_clr, w_tmr_clr, w_meas_entry;
    logic             w_store, w_done_set;
    logic             w_unused;

    // ---------------- Wishbone decode ----------------
    assign w_hit = wbs.wbs_stb_i & wbs.wbs_cyc_i &
                   (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // A request seen in the ack cycle is not accepted again, so back-to-back
    // strobes get at most every other cycle acknowledged.
    assign w_acc     = w_hit & ~r_ack;
    assign w_wr_ctrl = w_acc & wbs.wbs_we_i & (wbs.wbs_adr_i[3:2] == 2'd0) & wbs.wbs_sel_i[0];
    assign w_wr_gate = w_acc & wbs.wbs_we_i & (wbs.wbs_adr_i[3:2] == 2'd1);
    assign w_start   = w_wr_ctrl & wbs.wbs_dat_i[0];
    assign w_abort   = w_wr_ctrl & wbs.wbs_dat_i[5];
    // MASK written together with START takes effect for that START.
    assign w_mask_now = w_wr_ctrl ? wbs.wbs_dat_i[3:2] : r_mask;

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat_o;
    assign busy_o        = (r_state != S_IDLE);
    assign irq_o         = r_done;
    assign w_edge        = r_sync2[r_ch] & ~r_prev[r_ch];
    assign w_meas_entry  = (r_state == S_SETTLE) && (w_state_nxt == S_MEASURE);
    assign w_unused      = ^{wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3], wbs.wbs_dat_i[31:24]};

    always_comb begin
        w_rdata = '0;
        case (wbs.wbs_adr_i[3:2])
            2'd0:    w_rdata = {26'd0, 1'b0, r_done, r_mask, r_cont, 1'b0};
            2'd1:    w_rdata = {8'd0, r_gate};
            2'd2:    w_rdata = 32'(r_res_cnt[0]) | {r_res_vld[0], 31'd0};
            default: w_rdata = 32'(r_res_cnt[1]) | {r_res_vld[1], 31'd0};
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ch_nxt      = r_ch;
        w_sweep_start = 1'b0;
        w_valid_clr   = 1'b0;
        w_tmr_clr     = 1'b0;
        w_store       = 1'b0;
        w_done_set    = 1'b0;
        osc_en_o      = 2'b00;
        if (r_state != S_IDLE) osc_en_o[r_ch] = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_start && (w_mask_now != 2'b00)) begin
                    w_sweep_start = 1'b1;
                    w_valid_clr   = 1'b1;
                    w_tmr_clr     = 1'b1;
                    w_ch_nxt      = ~w_mask_now[0];
                    w_state_nxt   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_tmr == c_SETTLE_LAST) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (r_tmr == r_gate_act - 24'd1) w_state_nxt = S_STORE;
            end
            default: begin // S_STORE
                w_store   = 1'b1;
                w_tmr_clr = 1'b1;
                if (!r_ch && r_mask_act[1]) begin
                    w_ch_nxt    = 1'b1;
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_done_set = 1'b1;
                    // Continuous mode re-samples MASK/GATE but keeps the
                    // previous results VALID until they are overwritten.
                    if (r_cont && (w_mask_now != 2'b00)) begin
                        w_sweep_start = 1'b1;
                        w_ch_nxt      = ~w_mask_now[0];
                        w_state_nxt   = S_SETTLE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
        endcase
        // ABORT overrides everything, including a simultaneous START.
        if (w_abort) begin
            w_state_nxt   = S_IDLE;
            w_ch_nxt      = r_ch;
            w_sweep_start = 1'b0;
            w_valid_clr   = 1'b0;
            w_store       = 1'b0;
            w_done_set    = 1'b0;
        end
    end

    // ---------------- Datapath and registers ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack        <= 1'b0;
            r_dat_o      <= '0;
            r_cont       <= 1'b0;
            r_done       <= 1'b0;
            r_mask       <= 2'b00;
            r_mask_act   <= 2'b00;
            r_gate       <= 24'd1000;
            r_gate_act   <= 24'd1;
            r_tmr        <= '0;
            r_ch         <= 1'b0;
            r_cnt        <= '0;
            r_res_cnt[0] <= '0;
            r_res_cnt[1] <= '0;
            r_res_vld    <= 2'b00;
            r_sync1      <= 2'b00;
            r_sync2      <= 2'b00;
            r_prev       <= 2'b00;
        end else begin
            r_ack   <= w_acc;
            r_dat_o <= (w_acc && !wbs.wbs_we_i) ? w_rdata : 32'd0;

            if (w_wr_ctrl) begin
                r_cont <= wbs.wbs_dat_i[1];
                r_mask <= wbs.wbs_dat_i[3:2];
            end
            if (w_wr_gate) begin
                if (wbs.wbs_sel_i[0]) r_gate[7:0]   <= wbs.wbs_dat_i[7:0];
                if (wbs.wbs_sel_i[1]) r_gate[15:8]  <= wbs.wbs_dat_i[15:8];
                if (wbs.wbs_sel_i[2]) r_gate[23:16] <= wbs.wbs_dat_i[23:16];
            end
            // Hardware set wins over a simultaneous W1C.
            if (w_done_set)                           r_done <= 1'b1;
            else if (w_wr_ctrl && wbs.wbs_dat_i[4])   r_done <= 1'b0;

            if (w_sweep_start) begin
                r_mask_act <= w_mask_now;
                r_gate_act <= (r_gate == 24'd0) ? 24'd1 : r_gate;
            end
            if (w_valid_clr) r_res_vld <= r_res_vld & ~w_mask_now;

            r_ch  <= w_ch_nxt;
            r_tmr <= w_tmr_clr ? 24'd0 : r_tmr + 24'd1;

            // The detector tracks the level of both channels every cycle, so
            // the first MEASURE cycle can only report an edge that actually
            // arrived in that cycle; the count itself restarts at entry.
            r_sync1 <= osc_in_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_meas_entry)
                r_cnt <= '0;
            else if ((r_state == S_MEASURE) && w_edge && (r_cnt != c_CNT_MAX))
                r_cnt <= r_cnt + 1'b1;

            if (w_store) begin
                r_res_cnt[r_ch] <= r_cnt;
                r_res_vld[r_ch] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
